// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern generator.
// Every channel can be off, on, blinking with a programmable half-period,
// or breathing (triangle-ramped PWM duty against a shared PWM counter).
// The LED outputs are registered from pre-edge state, so they lag the
// internal phase/duty/PWM state by one clock.
module led_pattern_gen #(
    parameter int CHANNELS     = 4,
    parameter int DIV_WIDTH    = 16,
    parameter int PWM_WIDTH    = 8,
    parameter int DEFAULT_HALF = 4999,
    parameter int DEFAULT_MODE = 2,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [1:0]           cfg_mode,
    input  logic [DIV_WIDTH-1:0] cfg_half,
    output logic [CHANNELS-1:0]  led
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    localparam logic [PWM_WIDTH-1:0] PWM_MAX  = '1;
    localparam logic [PWM_WIDTH-1:0] PWM_ONE  = PWM_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] HALF_RST = DIV_WIDTH'(DEFAULT_HALF);
    localparam logic [1:0]           MODE_RST = 2'(DEFAULT_MODE);
    localparam logic [CH_W:0]        NUM_CH   = (CH_W + 1)'(CHANNELS);

    // Shared state
    logic [PWM_WIDTH-1:0] pwm_q, pwm_d;
    logic [CHANNELS-1:0]  led_q, led_d;

    // Per-channel state
    mode_e                mode_q   [CHANNELS];
    mode_e                mode_d   [CHANNELS];
    logic [DIV_WIDTH-1:0] half_q   [CHANNELS];
    logic [DIV_WIDTH-1:0] half_d   [CHANNELS];
    logic [DIV_WIDTH-1:0] div_q    [CHANNELS];
    logic [DIV_WIDTH-1:0] div_d    [CHANNELS];
    logic                 phase_q  [CHANNELS];
    logic                 phase_d  [CHANNELS];
    logic [PWM_WIDTH-1:0] duty_q   [CHANNELS];
    logic [PWM_WIDTH-1:0] duty_d   [CHANNELS];
    logic                 dir_up_q [CHANNELS];
    logic                 dir_up_d [CHANNELS];

    // Per-channel decode
    logic                 step_c   [CHANNELS];
    logic                 sel_c    [CHANNELS];
    logic                 wr_valid;

    // One breathe step: returns {dir_up_next, duty_next}. The endpoints are
    // never repeated: the turnaround step moves straight to MAX-1 or 1.
    function automatic logic [PWM_WIDTH:0] breathe_next(
        input logic [PWM_WIDTH-1:0] duty,
        input logic                 up
    );
        logic [PWM_WIDTH:0] r;
        if (up) begin
            if (duty == PWM_MAX) r = {1'b0, PWM_MAX - PWM_ONE};
            else                 r = {1'b1, duty + PWM_ONE};
        end else begin
            if (duty == '0)      r = {1'b1, PWM_ONE};
            else                 r = {1'b0, duty - PWM_ONE};
        end
        return r;
    endfunction

    // Writes to a channel index beyond CHANNELS are dropped entirely.
    assign wr_valid = cfg_we && ({1'b0, cfg_ch} < NUM_CH);

    // Shared PWM counter free-runs and wraps from MAX to 0 by overflow.
    assign pwm_d = pwm_q + PWM_ONE;

    assign led = led_q;

    // Per-channel step detection (divider terminal count) and write select.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            step_c[i] = (div_q[i] == half_q[i]);
            sel_c[i]  = wr_valid && (cfg_ch == CH_W'(i));
        end
    end

    // Per-channel next state: divider, blink phase, breathe ramp; a write
    // to the channel overrides any coincident step on that channel.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            mode_d[i]   = mode_q[i];
            half_d[i]   = half_q[i];
            div_d[i]    = step_c[i] ? '0 : div_q[i] + DIV_WIDTH'(1);
            phase_d[i]  = phase_q[i];
            duty_d[i]   = duty_q[i];
            dir_up_d[i] = dir_up_q[i];

            if (step_c[i]) begin
                case (mode_q[i])
                    MODE_BLINK:   phase_d[i] = ~phase_q[i];
                    MODE_BREATHE: {dir_up_d[i], duty_d[i]} = breathe_next(duty_q[i], dir_up_q[i]);
                    default:      ;
                endcase
            end

            if (sel_c[i]) begin
                mode_d[i]   = mode_e'(cfg_mode);
                half_d[i]   = cfg_half;
                div_d[i]    = '0;
                phase_d[i]  = 1'b0;
                duty_d[i]   = '0;
                dir_up_d[i] = 1'b1;
            end
        end
    end

    // LED drive computed from pre-edge mode, phase, duty and PWM count.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (mode_q[i])
                MODE_ON:      led_d[i] = 1'b1;
                MODE_BLINK:   led_d[i] = phase_q[i];
                MODE_BREATHE: led_d[i] = (pwm_q < duty_q[i]);
                default:      led_d[i] = 1'b0;
            endcase
        end
    end

    // State registers with asynchronous reset to the power-on defaults.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q <= '0;
            led_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= mode_e'(MODE_RST);
                half_q[i]   <= HALF_RST;
                div_q[i]    <= '0;
                phase_q[i]  <= 1'b0;
                duty_q[i]   <= '0;
                dir_up_q[i] <= 1'b1;
            end
        end else begin
            pwm_q <= pwm_d;
            led_q <= led_d;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= mode_d[i];
                half_q[i]   <= half_d[i];
                div_q[i]    <= div_d[i];
                phase_q[i]  <= phase_d[i];
                duty_q[i]   <= duty_d[i];
                dir_up_q[i] <= dir_up_d[i];
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen. Five channels (so channel indices 5..7 are
// out of range on the 3-bit address) and a 4-bit PWM. The reference model
// keeps, per channel, only the mode, half-period and the number of edges
// since the channel was last configured; blink phase and breathe duty are
// derived from that count arithmetically.
module tb_led_pattern_gen;

    localparam int CH   = 5;
    localparam int PWMW = 4;
    localparam int PMAX = (1 << PWMW) - 1;
    localparam int DEFH = 4999;
    localparam int DEFM = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [2:0]    cfg_ch;
    logic [1:0]    cfg_mode;
    logic [15:0]   cfg_half;
    logic [CH-1:0] led;

    int checks = 0;
    int errors = 0;
    int nprint = 0;

    // Reference model state
    int m_mode [CH];
    int m_half [CH];
    int m_n    [CH];
    int m_pwm;
    logic [CH-1:0] exp_led;

    led_pattern_gen #(
        .CHANNELS(CH), .DIV_WIDTH(16), .PWM_WIDTH(PWMW),
        .DEFAULT_HALF(DEFH), .DEFAULT_MODE(DEFM)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_half(cfg_half), .led(led)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_mode[c] = DEFM;
            m_half[c] = DEFH;
            m_n[c]    = 0;
        end
        m_pwm   = 0;
        exp_led = '0;
    endtask

    // LED value the model expects to be registered at the next edge.
    function automatic logic [CH-1:0] model_led();
        logic [CH-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            int s, p, duty;
            s = m_n[c] / (m_half[c] + 1);
            p = s % (2 * PMAX);
            duty = (p <= PMAX) ? p : (2 * PMAX - p);
            case (m_mode[c])
                1: r[c] = 1'b1;
                2: r[c] = (s % 2) == 1;
                3: r[c] = m_pwm < duty;
                default: r[c] = 1'b0;
            endcase
        end
        return r;
    endfunction

    // Apply one cycle of inputs, advance the clock and the model.
    task automatic tick(input logic we, input int ch, input int md, input int hf);
        cfg_we   = we;
        cfg_ch   = 3'(ch);
        cfg_mode = 2'(md);
        cfg_half = 16'(hf);
        @(posedge clk);
        exp_led = model_led();
        m_pwm = (m_pwm + 1) % (PMAX + 1);
        for (int c = 0; c < CH; c++) m_n[c]++;
        if (we && ch < CH) begin
            m_mode[ch] = md;
            m_half[ch] = hf;
            m_n[ch]    = 0;
        end
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_we = 0; cfg_ch = 0; cfg_mode = 0; cfg_half = 0;
        model_reset();
        #12;
        checks++;
        if (led !== '0) begin
            errors++; $display("FAIL reset_led led=%b required=%b", led, 5'b0);
        end
        rst = 1'b0;
        for (int e = 1; e <= 15002; e++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (led !== exp_led) begin
                errors++;
                if (nprint++ < 20) $display("FAIL reset_blink edge %0d led=%b required=%b", e, led, exp_led);
            end
            if (e == 5000 || e == 5001 || e == 10001 || e == 15001) begin
                logic [CH-1:0] want;
                want = (e == 5001 || e == 15001) ? '1 : '0;
                checks++;
                if (led !== want) begin
                    errors++; $display("FAIL reset_blink_edge%0d led=%b required=%b", e, led, want);
                end
            end
        end
    endtask

    task automatic test_fast_blink();
        tick(1, 1, 2, 3);
        for (int k = 1; k <= 40; k++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (led !== exp_led) begin
                errors++;
                if (nprint++ < 40) $display("FAIL fast_blink k=%0d led=%b required=%b", k, led, exp_led);
            end
            if (k <= 5) begin
                checks++;
                if (led[1] !== (k == 5)) begin
                    errors++; $display("FAIL fast_blink_first_rise k=%0d led1=%b required=%b", k, led[1], (k == 5));
                end
            end
        end
    endtask

    task automatic test_breathe();
        tick(1, 2, 3, 0);
        for (int k = 1; k <= 100; k++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (led !== exp_led) begin
                errors++;
                if (nprint++ < 60) $display("FAIL breathe k=%0d led=%b required=%b", k, led, exp_led);
            end
        end
    endtask

    task automatic test_precedence();
        tick(1, 3, 2, 5);
        for (int k = 1; k <= 5; k++) tick(0, 0, 0, 0);
        // Sixth edge after the write is the one where div == half.
        tick(1, 3, 2, 5);
        for (int j = 1; j <= 14; j++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (led !== exp_led) begin
                errors++;
                if (nprint++ < 80) $display("FAIL precedence j=%0d led=%b required=%b", j, led, exp_led);
            end
            if (j <= 7) begin
                checks++;
                if (led[3] !== (j == 7)) begin
                    errors++; $display("FAIL precedence_ch3 j=%0d led3=%b required=%b", j, led[3], (j == 7));
                end
            end
        end
        tick(1, 5, 1, 0);
        tick(1, 6, 0, 0);
        tick(1, 7, 3, 1);
        for (int k = 1; k <= 24; k++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (led !== exp_led) begin
                errors++;
                if (nprint++ < 100) $display("FAIL illegal_addr k=%0d led=%b required=%b", k, led, exp_led);
            end
        end
    endtask

    task automatic test_half0_onoff();
        logic prev0;
        tick(1, 0, 2, 0);
        tick(1, 4, 1, 7);
        tick(1, 1, 0, 9);
        tick(0, 0, 0, 0);
        prev0 = led[0];
        for (int k = 1; k <= 20; k++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (led !== exp_led) begin
                errors++;
                if (nprint++ < 120) $display("FAIL half0_onoff k=%0d led=%b required=%b", k, led, exp_led);
            end
            checks++;
            if (led[0] !== ~prev0 || led[4] !== 1'b1 || led[1] !== 1'b0) begin
                errors++;
                $display("FAIL half0_toggle_const k=%0d led0=%b led4=%b led1=%b required=%b,1,0",
                         k, led[0], led[4], led[1], ~prev0);
            end
            prev0 = led[0];
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 400; k++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                 $urandom_range(0, 3), $urandom_range(0, 4));
            checks++;
            if (led !== exp_led) begin
                errors++;
                if (nprint++ < 140) $display("FAIL back_to_back k=%0d led=%b required=%b", k, led, exp_led);
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1, 2, 3, 1);
        for (int k = 1; k <= 40; k++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (led !== exp_led) begin
                errors++;
                if (nprint++ < 160) $display("FAIL pre_reset k=%0d led=%b required=%b", k, led, exp_led);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (led !== '0) begin
            errors++; $display("FAIL async_reset_immediate led=%b required=%b", led, 5'b0);
        end
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (led !== '0) begin
            errors++; $display("FAIL async_reset_held led=%b required=%b", led, 5'b0);
        end
        #3;
        rst = 1'b0;
        for (int e = 1; e <= 5002; e++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (led !== exp_led) begin
                errors++;
                if (nprint++ < 180) $display("FAIL post_reset edge %0d led=%b required=%b", e, led, exp_led);
            end
            if (e == 5000 || e == 5001) begin
                logic [CH-1:0] want;
                want = (e == 5001) ? '1 : '0;
                checks++;
                if (led !== want) begin
                    errors++; $display("FAIL post_reset_edge%0d led=%b required=%b", e, led, want);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fast_blink();
        test_breathe();
        test_precedence();
        test_half0_onoff();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
